// File: rtl/apb_pkg.sv
// Shared types and error-cause codes for the APB register bridge.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} bridge_state_e;
  typedef enum logic [1:0] {RW, RO, WO} acc_mode_e;

  localparam int unsigned APB_ERR_W = 3;
  localparam logic [APB_ERR_W-1:0] APB_ERR_NONE     = 3'd0;
  localparam logic [APB_ERR_W-1:0] APB_ERR_MISALIGN = 3'd1;
  localparam logic [APB_ERR_W-1:0] APB_ERR_RANGE    = 3'd2;
  localparam logic [APB_ERR_W-1:0] APB_ERR_RO       = 3'd3;
  localparam logic [APB_ERR_W-1:0] APB_ERR_WO       = 3'd4;
  localparam logic [APB_ERR_W-1:0] APB_ERR_RSTRB    = 3'd5;
  localparam logic [APB_ERR_W-1:0] APB_ERR_RSVD     = 3'd6;

  // A register flagged both read-only and write-only is treated as read-only.
  function automatic acc_mode_e mode_of(input logic ro, input logic wo);
    if (ro)      return RO;
    else if (wo) return WO;
    else         return RW;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode and per-register access legality check.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned              ADDR_W    = 12,
  parameter int unsigned              DATA_W    = 32,
  parameter int unsigned              N_REGS    = 5,
  parameter int unsigned              ADDR_BASE = 0,
  parameter logic [N_REGS-1:0]        RO_MASK   = '0,
  parameter logic [N_REGS-1:0]        WO_MASK   = '0,
  parameter logic [N_REGS*DATA_W-1:0] RSVD_MASK = '0,
  parameter int unsigned              IDX_W     = 1
) (
  input  logic [ADDR_W-1:0]    paddr,
  input  logic                 pwrite,
  input  logic [DATA_W/8-1:0]  pstrb,
  input  logic [DATA_W-1:0]    pwdata,
  output logic [IDX_W-1:0]     idx,
  output logic                 legal,
  output logic [APB_ERR_W-1:0] cause
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;
  logic              hit;
  acc_mode_e         mode;
  logic [DATA_W-1:0] rsvd;
  logic [DATA_W-1:0] lane_mask;

  always_comb begin
    offset    = paddr - ADDR_W'(ADDR_BASE);
    word      = offset >> 2;
    idx       = '0;
    hit       = 1'b0;
    mode      = RW;
    rsvd      = '0;
    lane_mask = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (word == ADDR_W'(i)) begin
        idx  = IDX_W'(i);
        hit  = 1'b1;
        mode = mode_of(RO_MASK[i], WO_MASK[i]);
        rsvd = RSVD_MASK[i*DATA_W +: DATA_W];
      end
    end
    // Addresses below the base wrap around in the subtraction; reject them explicitly.
    if (paddr < ADDR_W'(ADDR_BASE)) hit = 1'b0;
    for (int unsigned b = 0; b < STRB_W; b++) lane_mask[b*8 +: 8] = {8{pstrb[b]}};

    cause = APB_ERR_NONE;
    if (paddr[1:0] != 2'b00)                            cause = APB_ERR_MISALIGN;
    else if (!hit)                                      cause = APB_ERR_RANGE;
    else if (pwrite && mode == RO)                      cause = APB_ERR_RO;
    else if (!pwrite && mode == WO)                     cause = APB_ERR_WO;
    else if (!pwrite && pstrb != '0)                    cause = APB_ERR_RSTRB;
    else if (pwrite && |(pwdata & rsvd & lane_mask))    cause = APB_ERR_RSVD;
    legal = (cause == APB_ERR_NONE);
  end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB4 completer front-end: decodes register accesses, runs a req/ack
// handshake to the register bank and bounds bank latency with a timeout.
module apb_reg_bridge
  import apb_pkg::*;
#(
  parameter int unsigned              ADDR_W    = 12,
  parameter int unsigned              DATA_W    = 32,
  parameter int unsigned              N_REGS    = 5,
  parameter int unsigned              ADDR_BASE = 0,
  parameter logic [N_REGS-1:0]        RO_MASK   = 5'b10010,
  parameter logic [N_REGS-1:0]        WO_MASK   = 5'b00000,
  parameter logic [N_REGS*DATA_W-1:0] RSVD_MASK = '0,
  parameter int unsigned              TIMEOUT   = 16,
  localparam int unsigned             IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   pwdata,
  output logic                pready,
  output logic                pslverr,
  output logic [DATA_W-1:0]   prdata,
  output logic                reg_req_o,
  output logic                reg_we_o,
  output logic [IDX_W-1:0]    reg_idx_o,
  output logic [DATA_W/8-1:0] reg_be_o,
  output logic [DATA_W-1:0]   reg_wdata_o,
  input  logic                reg_ack_i,
  input  logic [DATA_W-1:0]   reg_rdata_i,
  input  logic                reg_err_i
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned STRB_W = DATA_W / 8;

  bridge_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [STRB_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_legal;
  logic [APB_ERR_W-1:0] dec_cause;

  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .N_REGS    (N_REGS),
    .ADDR_BASE (ADDR_BASE),
    .RO_MASK   (RO_MASK),
    .WO_MASK   (WO_MASK),
    .RSVD_MASK (RSVD_MASK),
    .IDX_W     (IDX_W)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .pstrb  (pstrb),
    .pwdata (pwdata),
    .idx    (dec_idx),
    .legal  (dec_legal),
    .cause  (dec_cause)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = 1'b0;
    we_d      = we_q;
    idx_d     = idx_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        we_d    = 1'b0;
        idx_d   = '0;
        be_d    = '0;
        wdata_d = '0;
        if (psel && !penable) begin
          if (dec_legal) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = pwrite;
            idx_d   = dec_idx;
            be_d    = pwrite ? pstrb : '0;
            wdata_d = pwrite ? pwdata : '0;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      REQ, WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
          we_d    = 1'b0;
          idx_d   = '0;
          be_d    = '0;
          wdata_d = '0;
        end else if (reg_ack_i) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = reg_err_i;
          prdata_d  = we_q ? '0 : reg_rdata_i;
        end else if (state_q == REQ) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        we_d    = 1'b0;
        idx_d   = '0;
        be_d    = '0;
        wdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign prdata      = prdata_q;
  assign reg_req_o   = req_q;
  assign reg_we_o    = we_q;
  assign reg_idx_o   = idx_q;
  assign reg_be_o    = be_q;
  assign reg_wdata_o = wdata_q;

  // The decoder's legal flag and its cause code must never disagree.
  a_decode_consistent: assert property (@(posedge pclk) disable iff (preset)
    dec_legal == (dec_cause == APB_ERR_NONE));

endmodule
